// File: rtl/acc_stream_collector_pkg.sv
// Shared types for the serial accumulator collector: core index width and the
// tagged word that travels through the output FIFO.
package acc_stream_collector_pkg;

    localparam int CORE_IDX_W = 2;
    localparam int ACC_WORD_W = 8;

    typedef struct packed {
        logic [CORE_IDX_W-1:0] core;
        logic [ACC_WORD_W-1:0] data;
    } tagged_word_t;

endpackage

// File: rtl/acc_stream_collector_sync_fifo.sv
// Synchronous FIFO with a registered head word; push and pop in the same cycle
// keep the level unchanged, and pop while empty is ignored.
module acc_stream_collector_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             preset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_head;

    logic             w_pop;
    logic             w_push;
    logic [PTR_W-1:0] w_rd_next;
    logic [WIDTH-1:0] w_head_next;

    assign w_pop     = pop && (r_level != '0);
    assign w_push    = push && ((r_level != FULL_LVL) || w_pop);
    assign w_rd_next = r_rd_ptr + PTR_W'(w_pop);

    // The head register bypasses the array when the incoming word becomes the new head.
    assign w_head_next = (w_push && (r_wr_ptr == w_rd_next)) ? push_data : r_mem[w_rd_next];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!preset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            if (w_push || w_pop) begin
                r_head <= w_head_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign head_data = r_head;
    assign full      = (r_level == FULL_LVL);
    assign empty     = (r_level == '0);
    assign level     = r_level;

endmodule

// File: rtl/acc_stream_collector.sv
// Deserialises each core's 1-bit accumulator stream into words, tags them with
// the core index and queues them for a valid/ready consumer.
module acc_stream_collector
    import acc_stream_collector_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int WORD_W     = ACC_WORD_W,
    parameter int FIFO_DEPTH = 8,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  preset_n,
    input  logic                  capture_en,
    input  logic [NUM_CORES-1:0]  acc_bit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_W-1:0]     out_data,
    output logic [CORE_IDX_W-1:0] out_core,
    output logic                  overflow,
    output logic [LVL_W-1:0]      fifo_level
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0]     r_shift [NUM_CORES];
    logic [WORD_W-1:0]     r_hold  [NUM_CORES];
    logic [NUM_CORES-1:0]  r_pending;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_overflow;

    logic [WORD_W-1:0]     w_word_next [NUM_CORES];
    logic [NUM_CORES-1:0]  w_push_hit;
    logic                  w_word_done;
    logic                  w_pending_any;
    logic [CORE_IDX_W-1:0] w_push_idx;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    tagged_word_t          w_push_word;
    tagged_word_t          w_head_word;

    assign w_word_done = capture_en && (r_bit_cnt == LAST_BIT);
    assign w_pop       = !w_fifo_empty && out_ready;

    // Lowest-index pending core wins the single push slot.
    always_comb begin
        w_pending_any = 1'b0;
        w_push_idx    = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_pending_any = 1'b1;
                w_push_idx    = CORE_IDX_W'(i);
            end
        end
    end

    assign w_push           = w_pending_any && (!w_fifo_full || w_pop);
    assign w_push_word.core = w_push_idx;
    assign w_push_word.data = r_hold[w_push_idx];

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        assign w_word_next[gi] = {acc_bit[gi], r_shift[gi][WORD_W-1:1]};
        assign w_push_hit[gi]  = w_push && (w_push_idx == CORE_IDX_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (!preset_n) begin
            r_bit_cnt  <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_shift[i] <= '0;
                r_hold[i]  <= '0;
            end
        end else begin
            if (capture_en) begin
                r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + CNT_W'(1);
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (capture_en) begin
                    r_shift[i] <= w_word_next[i];
                end
                // A holding slot freed by this cycle's push can take the new word.
                if (w_word_done && (!r_pending[i] || w_push_hit[i])) begin
                    r_hold[i]    <= w_word_next[i];
                    r_pending[i] <= 1'b1;
                end else if (w_push_hit[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
            if (w_word_done && ((r_pending & ~w_push_hit) != '0)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    acc_stream_collector_sync_fifo #(
        .WIDTH ($bits(tagged_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .preset_n  (preset_n),
        .push      (w_push),
        .push_data (w_push_word),
        .pop       (w_pop),
        .head_data (w_head_word),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .level     (fifo_level)
    );

    assign out_valid = !w_fifo_empty;
    assign out_data  = w_head_word.data;
    assign out_core  = w_head_word.core;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_acc_stream_collector.sv
// Randomised and directed bench for acc_stream_collector against a queue-based
// behavioural model of the collector.
module tb_acc_stream_collector;

    logic       clk;
    logic       preset_n;
    logic       capture_en;
    logic [3:0] acc_bit;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_core;
    logic       overflow;
    logic [3:0] fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int         m_cnt;
    logic [7:0] m_acc  [4];
    logic [7:0] m_held [4];
    bit         m_pend [4];
    bit         m_ovf;
    logic [9:0] m_q   [$];
    logic [9:0] pop_log [$];

    acc_stream_collector dut (
        .clk        (clk),
        .preset_n   (preset_n),
        .capture_en (capture_en),
        .acc_bit    (acc_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_core   (out_core),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_q.delete();
        for (int i = 0; i < 4; i++) begin
            m_acc[i]  = 8'h00;
            m_held[i] = 8'h00;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit ce, input logic [3:0] bits, input bit rdy, input bit rstn);
        bit         pop;
        int         sel;
        logic [9:0] ent;
        if (!rstn) begin
            model_clear();
            return;
        end
        pop = (m_q.size() > 0) && rdy;
        sel = -1;
        for (int i = 0; i < 4; i++)
            if (m_pend[i] && sel < 0) sel = i;
        if (sel >= 0 && !(m_q.size() < 8 || pop)) sel = -1;
        if (pop) begin
            ent = m_q.pop_front();
            pop_log.push_back(ent);
            $display("pop core=%0d data=%02h level_before=%0d", ent[9:8], ent[7:0], m_q.size() + 1);
        end
        if (sel >= 0) begin
            m_q.push_back({2'(sel), m_held[sel]});
            m_pend[sel] = 1'b0;
        end
        if (ce) begin
            for (int i = 0; i < 4; i++)
                m_acc[i] = m_acc[i] | (8'(bits[i]) << m_cnt);
            m_cnt++;
            if (m_cnt == 8) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_pend[i]) m_ovf = 1'b1;
                    else begin
                        m_held[i] = m_acc[i];
                        m_pend[i] = 1'b1;
                    end
                    m_acc[i] = 8'h00;
                end
                m_cnt = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("valid", out_valid, m_q.size() > 0);
        check("level", fifo_level, m_q.size());
        check("overflow", overflow, m_ovf);
        if (m_q.size() > 0) begin
            check("head_data", out_data, m_q[0][7:0]);
            check("head_core", out_core, m_q[0][9:8]);
        end
    endtask

    task automatic tick(input bit ce, input logic [3:0] bits, input bit rdy, input bit rstn);
        capture_en = ce;
        acc_bit    = bits;
        out_ready  = rdy;
        preset_n   = rstn;
        @(posedge clk);
        model_step(ce, bits, rdy, rstn);
        #1;
        compare_all();
    endtask

    // words[8*i +: 8] is streamed LSB-first on core i
    task automatic send_words(input logic [31:0] words, input bit stall, input bit rdy);
        for (int b = 0; b < 8; b++) begin
            if (stall) tick(1'b0, 4'($urandom), rdy, 1'b1);
            tick(1'b1, {words[24+b], words[16+b], words[8+b], words[b]}, rdy, 1'b1);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) tick(1'b0, 4'($urandom), rdy, 1'b1);
    endtask

    logic [31:0] bp_words [4];
    logic [9:0]  exp_ent;

    initial begin
        capture_en = 1'b0;
        acc_bit    = '0;
        out_ready  = 1'b0;
        preset_n   = 1'b0;
        model_clear();

        // Reset with random stimulus
        tick(1'b1, 4'($urandom), 1'b1, 1'b0);
        tick(1'b1, 4'($urandom), 1'b1, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_core", out_core, 2'd0);

        // Basic ordering and latency
        pop_log.delete();
        send_words(32'h00FF3CA5, 1'b0, 1'b1);
        check("lat_edge0_valid", out_valid, 1'b0);
        tick(1'b0, 4'h0, 1'b1, 1'b1);
        check("lat_edge1_valid", out_valid, 1'b1);
        check("lat_edge1_data", out_data, 8'hA5);
        idle(6, 1'b1);
        check("basic_count", pop_log.size(), 4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++) begin
            case (i)
                0: exp_ent = {2'd0, 8'hA5};
                1: exp_ent = {2'd1, 8'h3C};
                2: exp_ent = {2'd2, 8'hFF};
                default: exp_ent = {2'd3, 8'h00};
            endcase
            check("basic_order", pop_log[i], exp_ent);
        end

        // capture_en toggling
        pop_log.delete();
        send_words(32'h81818181, 1'b1, 1'b1);
        idle(6, 1'b1);
        check("stall_count", pop_log.size(), 4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("stall_word", pop_log[i], {2'(i), 8'h81});

        // Backpressure: four words per core, the fourth is dropped
        pop_log.delete();
        for (int w = 0; w < 4; w++) begin
            bp_words[w] = $urandom;
            send_words(bp_words[w], 1'b0, 1'b0);
        end
        check("bp_level", fifo_level, 4'd8);
        check("bp_overflow", overflow, 1'b1);
        tick(1'b0, 4'h0, 1'b1, 1'b1);
        check("simul_level", fifo_level, 4'd8);
        idle(16, 1'b1);
        check("bp_count", pop_log.size(), 12);
        for (int k = 0; k < 12 && k < pop_log.size(); k++)
            check("bp_order", pop_log[k], {2'(k % 4), bp_words[k / 4][8*(k % 4) +: 8]});

        // Reset after a partial word
        pop_log.delete();
        for (int b = 0; b < 5; b++) tick(1'b1, 4'($urandom), 1'b1, 1'b1);
        tick(1'b0, 4'h0, 1'b1, 1'b0);
        check("mid_rst_overflow", overflow, 1'b0);
        send_words(32'h5A5A5A5A, 1'b0, 1'b1);
        idle(6, 1'b1);
        check("mid_rst_count", pop_log.size(), 4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            check("mid_rst_word", pop_log[i], {2'(i), 8'h5A});

        // Random traffic against the model
        tick(1'b0, 4'h0, 1'b0, 1'b0);
        for (int k = 0; k < 400; k++)
            tick(1'($urandom), 4'($urandom), $urandom_range(0, 3) != 0, 1'b1);
        idle(20, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
